instr_trace_buffer: RTL and testbench

- Downstream consumer of the single-cycle core's instruction output: Instruction_out_top, plus the PC that fetched it.
- Captures a triggered window of executed instructions into an internal FIFO.
- Lets a debug/UART drain side read them out at its own pace through a valid/ready handshake.
- Sits beside the core top, one instruction per clock on the input side.

---
 rtl/riscv_trace_pkg.sv | 19 +
 rtl/trace_fifo.sv | 64 ++++++
 rtl/instr_trace_buffer.sv | 107 ++++++++++
 tb/tb_instr_trace_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared definitions for the instruction trace buffer: capture states and
// the system-instruction encodings that can end a capture window.
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_e;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  function automatic logic is_sys_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO with flush. The caller guarantees push only when
// not full (or popping) and pop only when not empty.
module trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Flush wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_trace_buffer.sv
// Triggered capture of executed instructions into a FIFO, drained through a
// valid/ready port. Holds the capture FSM, trigger/stop decode and drop counter.
module instr_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_SYS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              instr_in,
  input  logic [31:0]              pc_in,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     flush,
  input  logic [31:0]              trig_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [1:0]               state_o
);

  trace_state_e     state_q, state_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             cap_req;
  logic             pop_do;
  logic             push_do;
  logic             drop_evt;
  logic             fifo_empty;
  logic [63:0]      head;

  // disarm beats arm, and arm beats trigger/stop; neither control pulse captures.
  always_comb begin
    state_d = state_q;
    cap_req = 1'b0;
    if (disarm) begin
      state_d = ST_STOPPED;
    end else if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (in_valid && (pc_in == trig_pc)) begin
            cap_req = 1'b1;
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (in_valid) begin
            cap_req = 1'b1;
            if ((STOP_ON_SYS != 0) && is_sys_instr(instr_in)) state_d = ST_STOPPED;
          end
        end
        default: ;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_do   = out_valid && out_ready;
  assign push_do  = cap_req && (!full || pop_do);
  assign drop_evt = cap_req && full && !pop_do && !flush;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_do),
    .pop   (pop_do),
    .flush (flush),
    .wdata ({instr_in, pc_in}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = head[63:32];
  assign out_pc    = head[31:0];
  assign drop_cnt  = drop_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed and randomized checks of instr_trace_buffer against a queue-based
// model of the capture rules.
module tb_instr_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        arm;
  logic        disarm;
  logic        flush;
  logic [31:0] trig_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  count;
  logic        full;
  logic [15:0] drop_cnt;
  logic [1:0]  state_o;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] model_q[$];
  int          model_state;
  int          model_drops;

  instr_trace_buffer #(
    .DEPTH       (DEPTH),
    .CNT_W       (CNT_W),
    .STOP_ON_SYS (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .arm       (arm),
    .disarm    (disarm),
    .flush     (flush),
    .trig_pc   (trig_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count),
    .full      (full),
    .drop_cnt  (drop_cnt),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: states 0..3, queue of {instr,pc}, saturating drop count.
  task automatic model_step(input bit r, input bit a, input bit d, input bit f,
                            input bit iv, input logic [31:0] ins,
                            input logic [31:0] pc, input bit rdy);
    bit cap;
    bit pop;
    bit was_full;
    if (r) begin
      model_q.delete();
      model_state = 0;
      model_drops = 0;
      return;
    end
    cap = 1'b0;
    if (d) model_state = 3;
    else if (a) model_state = 1;
    else if (model_state == 1 && iv && pc == trig_pc) begin
      cap = 1'b1;
      model_state = 2;
    end else if (model_state == 2 && iv) begin
      cap = 1'b1;
      if (ins == 32'h0000_0073 || ins == 32'h0010_0073) model_state = 3;
    end
    was_full = (model_q.size() == DEPTH);
    pop = (model_q.size() != 0) && rdy;
    if (f) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (cap) begin
        if (was_full && !pop) begin
          if (model_drops < 65535) model_drops++;
        end else begin
          model_q.push_back({ins, pc});
        end
      end
    end
  endtask

  task automatic compare_all();
    check_output("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check_output("out_instr", 64'(out_instr), 64'(model_q[0][63:32]));
      check_output("out_pc", 64'(out_pc), 64'(model_q[0][31:0]));
    end
    check_output("count", 64'(count), 64'(model_q.size()));
    check_output("full", 64'(full), 64'(model_q.size() == DEPTH));
    check_output("drop_cnt", 64'(drop_cnt), 64'(model_drops));
    check_output("state_o", 64'(state_o), 64'(model_state));
  endtask

  task automatic apply_stimulus(input bit r, input bit a, input bit d, input bit f,
                                input bit iv, input logic [31:0] ins,
                                input logic [31:0] pc, input bit rdy);
    rst       = r;
    arm       = a;
    disarm    = d;
    flush     = f;
    in_valid  = iv;
    instr_in  = ins;
    pc_in     = pc;
    out_ready = rdy;
    @(posedge clk);
    model_step(r, a, d, f, iv, ins, pc, rdy);
    #1;
    compare_all();
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] ins, input bit rdy);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ins, pc, rdy);
  endtask

  task automatic pulse_arm();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] drain_pcs [5];
    bit r, a, d, f, iv, rdy;
    logic [31:0] ins, pc;

    drain_pcs[0] = 32'h10; drain_pcs[1] = 32'h14; drain_pcs[2] = 32'h18;
    drain_pcs[3] = 32'h1C; drain_pcs[4] = 32'h20;
    trig_pc = 32'h10;
    model_q.delete();
    model_state = 0;
    model_drops = 0;

    $display("[TB] reset");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_output("reset_state", 64'(state_o), 64'd0);
    check_output("reset_count", 64'(count), 64'd0);

    $display("[TB] trigger capture");
    pulse_arm();
    for (int i = 0; i < 8; i++) begin
      feed(32'(4 * i), 32'h0050_0093, 1'b0);
      if (i == 4) begin
        check_output("trig_head_valid", 64'(out_valid), 64'd1);
        check_output("trig_head_pc", 64'(out_pc), 64'h10);
      end
    end
    check_output("trig_count", 64'(count), 64'd4);
    check_output("trig_state", 64'(state_o), 64'd2);

    $display("[TB] ecall stop");
    feed(32'h20, 32'h0000_0073, 1'b0);
    feed(32'h24, 32'h0050_0093, 1'b0);
    feed(32'h28, 32'h0050_0093, 1'b0);
    check_output("ecall_state", 64'(state_o), 64'd3);
    check_output("ecall_count", 64'(count), 64'd5);

    $display("[TB] drain with back-pressure");
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) check_output("drain_order", 64'(out_pc), 64'(drain_pcs[i / 2]));
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, (i % 2) == 0);
    end
    check_output("drain_count", 64'(count), 64'd0);
    check_output("drain_valid", 64'(out_valid), 64'd0);

    $display("[TB] overflow");
    trig_pc = 32'h100;
    pulse_arm();
    for (int i = 0; i < 20; i++) feed(32'h100 + 32'(4 * i), 32'h0050_0093 + 32'(i), 1'b0);
    check_output("ovf_full", 64'(full), 64'd1);
    check_output("ovf_count", 64'(count), 64'd16);
    check_output("ovf_drops", 64'(drop_cnt), 64'd4);
    feed(32'h150, 32'h0050_0093, 1'b1);
    check_output("ovf_pop_count", 64'(count), 64'd16);
    check_output("ovf_pop_drops", 64'(drop_cnt), 64'd4);
    check_output("ovf_pop_head", 64'(out_pc), 64'h104);

    $display("[TB] flush and priority");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0050_0093, 32'h154, 1'b1);
    check_output("flush_count", 64'(count), 64'd0);
    check_output("flush_drops", 64'(drop_cnt), 64'd4);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0050_0093, 32'h158, 1'b0);
    check_output("arm_disarm_state", 64'(state_o), 64'd3);

    $display("[TB] reset mid-capture");
    trig_pc = 32'h200;
    pulse_arm();
    for (int i = 0; i < 7; i++) feed(32'h200 + 32'(4 * i), 32'h0050_0093, 1'b0);
    check_output("pre_rst_count", 64'(count), 64'd7);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h21C, 1'b1);
    check_output("rst_state", 64'(state_o), 64'd0);
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_valid", 64'(out_valid), 64'd0);
    check_output("rst_drops", 64'(drop_cnt), 64'd0);
    feed(32'h200, 32'h0050_0093, 1'b0);
    feed(32'h200, 32'h0050_0093, 1'b0);
    check_output("no_arm_count", 64'(count), 64'd0);

    $display("[TB] randomized traffic");
    trig_pc = 32'h40;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      a   = ($urandom_range(0, 11) == 0);
      d   = ($urandom_range(0, 39) == 0);
      f   = ($urandom_range(0, 49) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      pc  = 32'h30 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ins = $urandom_range(0, 1) ? 32'h0000_0073 : 32'h0010_0073;
      else ins = $urandom;
      apply_stimulus(r, a, d, f, iv, ins, pc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
